// File: rtl/psl_job_driver_pkg.sv
// Shared definitions for the PSL job-control driver: command op encodings,
// one-hot state encodings and the op-to-job-command mapping.
package psl_job_driver_pkg;

  localparam logic [1:0] OP_RESET    = 2'd0;
  localparam logic [1:0] OP_START    = 2'd1;
  localparam logic [1:0] OP_TIMEBASE = 2'd2;
  localparam logic [1:0] OP_ILLEGAL  = 2'd3;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_ISSUE     = 5'b00010,
    ST_WAIT_RUN  = 5'b00100,
    ST_WAIT_DONE = 5'b01000,
    ST_REPORT    = 5'b10000
  } state_e;

  // An illegal op still produces a job command cycle, carrying code 8'h00.
  function automatic logic [7:0] op_code(input logic [1:0] op,
                                         input logic [7:0] j_reset,
                                         input logic [7:0] j_start,
                                         input logic [7:0] j_timebase);
    logic [7:0] code;
    case (op)
      OP_RESET:    code = j_reset;
      OP_START:    code = j_start;
      OP_TIMEBASE: code = j_timebase;
      default:     code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/psl_job_driver_parity.sv
// Reduction parity generator; odd_i=1 makes the field plus parity bit carry
// an odd number of ones, odd_i=0 an even number.
module psl_job_driver_parity #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] data_i,
  input  logic            odd_i,
  output logic            par_o
);

  assign par_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/psl_job_driver.sv
// Job-control initiator toward an AFU: issues one parity-protected job command
// per accepted request and reports completion, AFU-side error or timeout.
module psl_job_driver
  import psl_job_driver_pkg::*;
#(
  parameter logic [7:0]  J_RESET    = 8'h80,
  parameter logic [7:0]  J_START    = 8'h90,
  parameter logic [7:0]  J_TIMEBASE = 8'h42,
  parameter logic        ODD_PARITY = 1'b1,
  parameter logic [31:0] TIMEOUT    = 32'd100000
) (
  input  logic        ha_pclock,
  input  logic        ha_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [0:63] cmd_ea,
  input  logic        cmd_bad_par,
  output logic        ha_jval,
  output logic [0:7]  ha_jcom,
  output logic        ha_jcompar,
  output logic [0:63] ha_jea,
  output logic        ha_jeapar,
  input  logic        ah_jrunning,
  input  logic        ah_jdone,
  input  logic [0:63] ah_jerror,
  output logic        stat_valid,
  output logic [0:63] stat_error,
  output logic        stat_timeout,
  output logic        stat_no_run,
  output logic        unexp_done
);

  state_e      state_q;
  logic [1:0]  op_q;
  logic [31:0] cnt_q;
  logic        cmd_ready_q;
  logic        jval_q;
  logic [0:7]  jcom_q;
  logic [0:63] jea_q;
  logic        jcompar_q;
  logic        jeapar_q;
  logic        stat_valid_q;
  logic [0:63] stat_error_q;
  logic        stat_timeout_q;
  logic        stat_no_run_q;
  logic        unexp_done_q;

  logic        accept_s;
  logic        inject_s;
  logic        timeout_hit_s;
  logic [0:7]  jcom_d;
  logic [0:63] jea_d;
  logic        compar_s;
  logic        eapar_s;

  // The wire fields are loaded on the accept edge so ha_jval lands in the
  // cycle after acceptance; at every other edge they fall back to zero.
  always_comb begin
    accept_s      = (state_q == ST_IDLE) && cmd_valid;
    inject_s      = accept_s && cmd_bad_par;
    timeout_hit_s = (cnt_q == (TIMEOUT - 32'd1));
    if (accept_s) begin
      jcom_d = op_code(cmd_op, J_RESET, J_START, J_TIMEBASE);
      jea_d  = cmd_ea;
    end else begin
      jcom_d = 8'h00;
      jea_d  = 64'h0;
    end
  end

  psl_job_driver_parity #(.BITS(8)) u_compar (
    .data_i (jcom_d),
    .odd_i  (ODD_PARITY),
    .par_o  (compar_s)
  );

  psl_job_driver_parity #(.BITS(64)) u_eapar (
    .data_i (jea_d),
    .odd_i  (ODD_PARITY),
    .par_o  (eapar_s)
  );

  // Control FSM with all interface outputs registered.
  always_ff @(posedge ha_pclock or negedge ha_reset_n) begin
    if (!ha_reset_n) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_RESET;
      cnt_q          <= 32'd0;
      cmd_ready_q    <= 1'b1;
      jval_q         <= 1'b0;
      jcom_q         <= 8'h00;
      jea_q          <= 64'h0;
      jcompar_q      <= ODD_PARITY;
      jeapar_q       <= ODD_PARITY;
      stat_valid_q   <= 1'b0;
      stat_error_q   <= 64'h0;
      stat_timeout_q <= 1'b0;
      stat_no_run_q  <= 1'b0;
      unexp_done_q   <= 1'b0;
    end else begin
      jval_q       <= 1'b0;
      jcom_q       <= jcom_d;
      jea_q        <= jea_d;
      jcompar_q    <= compar_s ^ inject_s;
      jeapar_q     <= eapar_s ^ inject_s;
      stat_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ah_jdone) begin
            unexp_done_q <= 1'b1;
          end
          if (cmd_valid) begin
            state_q     <= ST_ISSUE;
            op_q        <= cmd_op;
            jval_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
          end
        end

        ST_ISSUE: begin
          cnt_q <= 32'd0;
          case (op_q)
            OP_START:    state_q <= ST_WAIT_RUN;
            OP_TIMEBASE: begin
              state_q        <= ST_REPORT;
              stat_valid_q   <= 1'b1;
              stat_error_q   <= 64'h0;
              stat_timeout_q <= 1'b0;
              stat_no_run_q  <= 1'b0;
            end
            default:     state_q <= ST_WAIT_DONE;
          endcase
        end

        // A done here means the AFU finished without ever reporting running.
        ST_WAIT_RUN: begin
          if (ah_jdone) begin
            state_q        <= ST_REPORT;
            stat_valid_q   <= 1'b1;
            stat_error_q   <= ah_jerror;
            stat_timeout_q <= 1'b0;
            stat_no_run_q  <= 1'b1;
          end else if (timeout_hit_s) begin
            state_q        <= ST_REPORT;
            stat_valid_q   <= 1'b1;
            stat_error_q   <= 64'h0;
            stat_timeout_q <= 1'b1;
            stat_no_run_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (ah_jrunning) begin
              state_q <= ST_WAIT_DONE;
            end
          end
        end

        ST_WAIT_DONE: begin
          if (ah_jdone) begin
            state_q        <= ST_REPORT;
            stat_valid_q   <= 1'b1;
            stat_error_q   <= ah_jerror;
            stat_timeout_q <= 1'b0;
            stat_no_run_q  <= 1'b0;
          end else if (timeout_hit_s) begin
            state_q        <= ST_REPORT;
            stat_valid_q   <= 1'b1;
            stat_error_q   <= 64'h0;
            stat_timeout_q <= 1'b1;
            stat_no_run_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        ST_REPORT: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign ha_jval      = jval_q;
  assign ha_jcom      = jcom_q;
  assign ha_jcompar   = jcompar_q;
  assign ha_jea       = jea_q;
  assign ha_jeapar    = jeapar_q;
  assign stat_valid   = stat_valid_q;
  assign stat_error   = stat_error_q;
  assign stat_timeout = stat_timeout_q;
  assign stat_no_run  = stat_no_run_q;
  assign unexp_done   = unexp_done_q;

endmodule
